// File: rtl/xor_gate_if.sv
// Operand/result bundle for the ternary XOR primitive.
// Lane i of each bus occupies bits [2i+1:2i]; err carries one flag per lane.
interface xor_gate_if #(
    parameter int unsigned NUM_TRITS = 1
);
    logic [2*NUM_TRITS-1:0] a;
    logic [2*NUM_TRITS-1:0] b;
    logic [2*NUM_TRITS-1:0] c;
    logic [NUM_TRITS-1:0]   err;

    // Producer of operands, consumer of results.
    modport master (
        output a,
        output b,
        input  c,
        input  err
    );

    // The gate itself.
    modport slave (
        input  a,
        input  b,
        output c,
        output err
    );
endinterface

// File: rtl/xor_gate.sv
// Ternary XOR: per-lane modulo-3 sum of unsigned trits (00=0, 01=1, 10=2, 11=invalid).
// Lanes are independent, the result is registered with one cycle of latency, and an
// invalid operand forces that lane to 0 with its err flag raised for that cycle only.
module xor_gate #(
    parameter int unsigned NUM_TRITS = 1
) (
    input logic       clk,
    input logic       rst,
    xor_gate_if.slave bus
);

    logic [2*NUM_TRITS-1:0] c_d;
    logic [2*NUM_TRITS-1:0] c_q;
    logic [NUM_TRITS-1:0]   err_d;
    logic [NUM_TRITS-1:0]   err_q;

    // Per-lane next result: modulo-3 sum, or 0 plus error on an invalid encoding.
    always_comb begin
        logic [1:0] trit_a;
        logic [1:0] trit_b;
        logic [2:0] sum;
        c_d    = '0;
        err_d  = '0;
        trit_a = '0;
        trit_b = '0;
        sum    = '0;
        for (int i = 0; i < NUM_TRITS; i++) begin
            trit_a = bus.a[2*i +: 2];
            trit_b = bus.b[2*i +: 2];
            sum    = {1'b0, trit_a} + {1'b0, trit_b};
            if (trit_a == 2'b11 || trit_b == 2'b11) begin
                err_d[i]       = 1'b1;
                c_d[2*i +: 2]  = 2'b00;
            end else if (sum >= 3'd3) begin
                // Valid operands sum to at most 4, so one subtraction wraps it.
                c_d[2*i +: 2]  = 2'(sum - 3'd3);
            end else begin
                c_d[2*i +: 2]  = sum[1:0];
            end
        end
    end

    // Result registers; asynchronous reset discards any pending result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_q   <= '0;
            err_q <= '0;
        end else begin
            c_q   <= c_d;
            err_q <= err_d;
        end
    end

    assign bus.c   = c_q;
    assign bus.err = err_q;

endmodule

// File: tb/tb_xor_gate.sv
// Self-checking bench for xor_gate: directed cases plus randomized lanes against a
// trit-level arithmetic model, on a 1-lane and a 4-lane instance sharing clock/reset.
module tb_xor_gate;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    xor_gate_if #(.NUM_TRITS(1)) if1 ();
    xor_gate_if #(.NUM_TRITS(4)) if4 ();

    xor_gate #(.NUM_TRITS(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    xor_gate #(.NUM_TRITS(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: decode each trit to an integer, add, reduce mod 3.
    function automatic void model(input logic [7:0] a, input logic [7:0] b, input int n,
                                  output logic [7:0] c, output logic [3:0] e);
        int x;
        int y;
        c = '0;
        e = '0;
        for (int i = 0; i < n; i++) begin
            x = int'(a[2*i +: 2]);
            y = int'(b[2*i +: 2]);
            if (x == 3 || y == 3) begin
                e[i] = 1'b1;
            end else begin
                c[2*i +: 2] = 2'((x + y) % 3);
            end
        end
    endfunction

    logic [7:0] exp_c;
    logic [3:0] exp_e;
    logic [1:0] ta;
    logic [1:0] tb;
    bit         rst_cycle;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst   = 1'b1;
        if1.a = 2'b10;
        if1.b = 2'b10;
        if4.a = 8'b10_10_10_10;
        if4.b = 8'b10_10_10_10;

        // Held in reset with nonzero operands: outputs stay cleared.
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rst_c1", 32'(if1.c), 32'h0);
            check("rst_err1", 32'(if1.err), 32'h0);
            check("rst_c4", 32'(if4.c), 32'h0);
        end
        rst = 1'b0;

        // All nine valid pairs on the single-lane instance.
        for (int x = 0; x < 3; x++) begin
            for (int y = 0; y < 3; y++) begin
                if1.a = 2'(x);
                if1.b = 2'(y);
                tick();
                check("sweep_c", 32'(if1.c), 32'((x + y) % 3));
                check("sweep_err", 32'(if1.err), 32'h0);
            end
        end

        // Invalid operand, then recovery on the following valid pair.
        if1.a = 2'b11;
        if1.b = 2'b01;
        tick();
        check("inv_c", 32'(if1.c), 32'h0);
        check("inv_err", 32'(if1.err), 32'h1);
        if1.a = 2'b01;
        if1.b = 2'b01;
        tick();
        check("recov_c", 32'(if1.c), 32'h2);
        check("recov_err", 32'(if1.err), 32'h0);

        // Four independent lanes.
        if4.a = 8'b10_01_00_10;
        if4.b = 8'b10_10_01_00;
        tick();
        check("lanes4_c", 32'(if4.c), 32'b01_00_01_10);
        check("lanes4_err", 32'(if4.err), 32'h0);

        // One invalid lane leaves its neighbours alone.
        if4.a = 8'b00_00_11_10;
        if4.b = 8'b00_00_00_01;
        tick();
        check("lane_inv_c", 32'(if4.c), 32'h0);
        check("lane_inv_err", 32'(if4.err), 32'b0010);
        if4.a = 8'b00_00_11_01;
        if4.b = 8'b00_00_00_01;
        tick();
        check("lane_mix_c", 32'(if4.c), 32'b00_00_00_10);
        check("lane_mix_err", 32'(if4.err), 32'b0010);

        // Asynchronous reset between edges clears c before the next edge.
        check("pre_async_c", 32'(if1.c), 32'h2);
        #2;
        rst = 1'b1;
        #1;
        check("async_c", 32'(if1.c), 32'h0);
        if1.a = 2'b10;
        if1.b = 2'b10;
        tick();
        check("async_hold_c", 32'(if1.c), 32'h0);
        rst = 1'b0;
        tick();
        check("post_rst_c", 32'(if1.c), 32'h1);
        check("post_rst_err", 32'(if1.err), 32'h0);

        // Randomized operands (including invalid encodings) and occasional resets.
        for (int k = 0; k < 300; k++) begin
            rst_cycle = ($urandom_range(0, 19) == 0);
            rst   = rst_cycle;
            if1.a = 2'($urandom);
            if1.b = 2'($urandom);
            if4.a = 8'($urandom);
            if4.b = 8'($urandom);
            ta    = if1.a;
            tb    = if1.b;
            tick();
            if (rst_cycle) begin
                exp_c = '0;
                exp_e = '0;
            end else begin
                model({6'b0, ta}, {6'b0, tb}, 1, exp_c, exp_e);
            end
            check("rnd_c1", 32'(if1.c), 32'(exp_c[1:0]));
            check("rnd_err1", 32'(if1.err), 32'(exp_e[0]));
            if (!rst_cycle) model(if4.a, if4.b, 4, exp_c, exp_e);
            check("rnd_c4", 32'(if4.c), 32'(exp_c));
            check("rnd_err4", 32'(if4.err), 32'(exp_e));
            check("rnd_no11", 32'((if4.c[1:0] == 2'b11) || (if4.c[3:2] == 2'b11) ||
                                  (if4.c[5:4] == 2'b11) || (if4.c[7:6] == 2'b11)), 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
